// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared types and constants for the register hazard scoreboard
//
// Purpose: forward-select encoding and named producer latencies used by the
// scoreboard top, its per-register entries and the EX-stage operand muxes.
package hazard_scoreboard_pkg;

  // Width of one forward select. Two bits cover a forwarding depth of up to 3.
  localparam int FWD_SEL_W     = 2;
  localparam int FWD_DEPTH_MAX = (1 << FWD_SEL_W) - 1;

  // Stage k after EX maps to encoding k, so the age of a producer is directly
  // the select value.
  typedef enum logic [FWD_SEL_W-1:0] {
    FWD_NONE   = 2'd0,
    FWD_EX_MEM = 2'd1,
    FWD_MEM_WB = 2'd2,
    FWD_STAGE3 = 2'd3
  } fwd_src_e;

  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// rtl/hazard_scoreboard_sb_entry.sv - per-register latency/age tracker
//
// Purpose: tracks the last in-flight writer of one architectural register.
//   cnt: stall cycles left before the value can be forwarded/read.
//   age: cycles since the writer issued, saturating at AGE_SAT.
// Ports:
//   clock, reset  core clock, synchronous active-high reset
//   wr_en_i       a new writer of this register issues this cycle
//   wr_cnt_i      stall cycles the new writer imposes (latency - 1)
//   busy_o        cnt != 0, readers must stall
//   age_o         current age, used to pick the forwarding stage
module sb_entry
  import hazard_scoreboard_pkg::*;
#(
  parameter int CNT_W   = 3,
  parameter int AGE_W   = 2,
  parameter int AGE_SAT = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [CNT_W-1:0] wr_cnt_i,
  output logic             busy_o,
  output logic [AGE_W-1:0] age_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AGE_W-1:0] age_q, age_d;

  // A new writer overrides the running countdown: the newest writer wins.
  always_comb begin
    cnt_d = cnt_q;
    age_d = age_q;
    if (wr_en_i) begin
      cnt_d = wr_cnt_i;
      age_d = AGE_W'(1);
    end else begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      if (age_q != AGE_W'(AGE_SAT)) begin
        age_d = age_q + AGE_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      age_q <= AGE_W'(AGE_SAT);
    end else begin
      cnt_q <= cnt_d;
      age_q <= age_d;
    end
  end

  assign busy_o = (cnt_q != '0);
  assign age_o  = age_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - register scoreboard: ID stall and EX forward selects
//
// Purpose: at the ID->EX boundary, stalls ID while any used source register
// has an unresolved in-flight writer, and registers a per-source forward
// select for the instruction entering EX.
// Optional feature macro: SB_PERF_CNT_EN adds stall/issue performance counters.
// Ports:
//   clock, reset         core clock, synchronous active-high reset
//   issue_valid_ip       ID presents a valid instruction
//   issue_rd_we_ip       instruction writes issue_rd_ip
//   issue_rd_ip          destination register
//   issue_lat_ip         producer latency (0 -> 1, clamped to MAX_LAT)
//   issue_rs_ip          packed source registers, source i at [i*REG_AW +: REG_AW]
//   issue_rs_used_ip     per-source "operand actually read"
//   flush_en_ip          kill the instruction in ID this cycle
//   issue_ready_op       0 = stall ID/IF (combinational)
//   issue_fire_op        valid & ready & !flush (combinational)
//   fwd_sel_op           registered fwd_src_e per source, valid while in EX
//   perf_stall_cnt_op    (SB_PERF_CNT_EN) stalled cycles
//   perf_issue_cnt_op    (SB_PERF_CNT_EN) issued instructions
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_REGS  = 32,
  parameter int REG_AW    = $clog2(NUM_REGS),
  parameter int NUM_SRC   = 2,
  parameter int MAX_LAT   = 4,
  parameter int FWD_DEPTH = 2,    // must not exceed FWD_DEPTH_MAX
  parameter int CNT_W     = $clog2(MAX_LAT + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          issue_valid_ip,
  input  logic                          issue_rd_we_ip,
  input  logic [REG_AW-1:0]             issue_rd_ip,
  input  logic [CNT_W-1:0]              issue_lat_ip,
  input  logic [NUM_SRC*REG_AW-1:0]     issue_rs_ip,
  input  logic [NUM_SRC-1:0]            issue_rs_used_ip,
  input  logic                          flush_en_ip,
  output logic                          issue_ready_op,
  output logic                          issue_fire_op,
`ifdef SB_PERF_CNT_EN
  output logic [31:0]                   perf_stall_cnt_op,
  output logic [31:0]                   perf_issue_cnt_op,
`endif
  output logic [NUM_SRC*FWD_SEL_W-1:0]  fwd_sel_op
);

  localparam int AGE_SAT = FWD_DEPTH + 1;
  localparam int AGE_W   = $clog2(FWD_DEPTH + 2);

  logic [NUM_REGS-1:0] busy_vec;
  logic [AGE_W-1:0]    age_vec [NUM_REGS];
  logic [CNT_W-1:0]    lat_eff;
  logic [CNT_W-1:0]    wr_cnt;
  logic [NUM_SRC-1:0]  hazard;
  logic [REG_AW-1:0]   rs_idx;
  logic                stall;

  logic [NUM_SRC*FWD_SEL_W-1:0] fwd_cand;
  logic [NUM_SRC*FWD_SEL_W-1:0] fwd_sel_q, fwd_sel_d;

  // Latency 0 behaves as a single-cycle producer; anything longer than the
  // deepest pipe is clamped so the counter never exceeds MAX_LAT-1.
  always_comb begin
    lat_eff = issue_lat_ip;
    if (issue_lat_ip == '0) begin
      lat_eff = CNT_W'(1);
    end else if (issue_lat_ip > CNT_W'(MAX_LAT)) begin
      lat_eff = CNT_W'(MAX_LAT);
    end
    wr_cnt = lat_eff - CNT_W'(1);
  end

  // x0 is hardwired: never busy, always "old".
  assign busy_vec[0] = 1'b0;
  assign age_vec[0]  = AGE_W'(AGE_SAT);

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    logic wr_en;
    assign wr_en = issue_fire_op & issue_rd_we_ip & (issue_rd_ip == REG_AW'(r));

    sb_entry #(
      .CNT_W   (CNT_W),
      .AGE_W   (AGE_W),
      .AGE_SAT (AGE_SAT)
    ) u_entry (
      .clock    (clock),
      .reset    (reset),
      .wr_en_i  (wr_en),
      .wr_cnt_i (wr_cnt),
      .busy_o   (busy_vec[r]),
      .age_o    (age_vec[r])
    );
  end

  // Source lookups use the pre-update entries, so an instruction never
  // hazards on its own destination. An unused source, x0, or a producer older
  // than the forwarding window all yield FWD_NONE (encoding 0).
  always_comb begin
    hazard   = '0;
    fwd_cand = '0;
    rs_idx   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rs_idx = issue_rs_ip[i*REG_AW +: REG_AW];
      if (issue_rs_used_ip[i] && (rs_idx != '0) && (int'(rs_idx) < NUM_REGS)) begin
        hazard[i] = busy_vec[rs_idx];
        if ((age_vec[rs_idx] >= AGE_W'(1)) && (age_vec[rs_idx] <= AGE_W'(FWD_DEPTH))) begin
          fwd_cand[i*FWD_SEL_W +: FWD_SEL_W] = FWD_SEL_W'(age_vec[rs_idx]);
        end
      end
    end
  end

  assign issue_ready_op = ~|hazard;
  assign issue_fire_op  = issue_valid_ip & issue_ready_op & ~flush_en_ip;
  assign stall          = issue_valid_ip & ~issue_ready_op & ~flush_en_ip;

  // Stalls and flushes put a bubble into EX; idle cycles keep the old select.
  always_comb begin
    fwd_sel_d = fwd_sel_q;
    if (issue_fire_op) begin
      fwd_sel_d = fwd_cand;
    end else if ((issue_valid_ip & ~issue_ready_op) | flush_en_ip) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        fwd_sel_d[i*FWD_SEL_W +: FWD_SEL_W] = FWD_NONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fwd_sel_q <= '0;
    end else begin
      fwd_sel_q <= fwd_sel_d;
    end
  end

  assign fwd_sel_op = fwd_sel_q;

`ifdef SB_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_issue_q, perf_issue_d;

  // Both counters wrap naturally at 2^32.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_issue_d = perf_issue_q;
    if (stall) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
    if (issue_fire_op) begin
      perf_issue_d = perf_issue_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_issue_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_issue_q <= perf_issue_d;
    end
  end

  assign perf_stall_cnt_op = perf_stall_q;
  assign perf_issue_cnt_op = perf_issue_q;
`else
  logic unused_stall;
  assign unused_stall = stall;
`endif

endmodule
